// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle for bin2bcd_seq: operand request side and BCD result side.
// master = producer/consumer of the converter, slave = the converter itself.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  neg_out;
    logic                  busy;

    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out, neg_out, busy
    );

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out, neg_out, busy
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (double dabble), one operand bit per clock.
// Define BIN2BCD_SIGNED_EN to treat bin_in as two's complement and report the sign on neg_out.
module bin2bcd_seq #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    bin2bcd_seq_if.slave  bus
);
    // ceil(BIN_W * log10(2)) in integer arithmetic
    localparam int MIN_DIGITS = (BIN_W * 30103 + 99999) / 100000;
    localparam int CNT_W      = $clog2(BIN_W + 1);
    localparam int BCD_W      = 4 * DIGITS;

    generate
        if (BIN_W < 4 || DIGITS < MIN_DIGITS) begin : g_param_check
            $error("bin2bcd_seq: BIN_W must be >= 4 and DIGITS >= ceil(BIN_W*log10(2))");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [BIN_W-1:0]   r_bin;
    logic [BIN_W-1:0]   w_load;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [BCD_W-1:0]   w_bcd_shift;
    logic [BCD_W-1:0]   r_bcd_out;
    logic               w_accept;
    logic               w_last;

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_last   = (r_state == S_SHIFT) && (r_count == CNT_W'(1));

`ifdef BIN2BCD_SIGNED_EN
    logic w_neg;
    logic r_neg;
    logic r_neg_out;

    assign w_neg       = bus.bin_in[BIN_W-1];
    // Unsigned reinterpretation of the negation makes -2^(BIN_W-1) load as 2^(BIN_W-1)
    assign w_load      = w_neg ? -bus.bin_in : bus.bin_in;
    assign bus.neg_out = r_neg_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg     <= 1'b0;
            r_neg_out <= 1'b0;
        end else if (clr) begin
            r_neg     <= 1'b0;
            r_neg_out <= 1'b0;
        end else if (w_accept) begin
            r_neg <= w_neg;
        end else if (w_last) begin
            r_neg_out <= r_neg;
        end
    end
`else
    assign w_load      = bus.bin_in;
    assign bus.neg_out = 1'b0;
`endif

    // Add-3 correction looks at digits as they stand before this cycle's shift.
    // NOTE: default assignment first so no path through always_comb leaves a signal unassigned (no latch).
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_bcd_shift = {w_bcd_adj[BCD_W-2:0], r_bin[BIN_W-1]};

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
                S_SHIFT: if (w_last) w_state_nxt = S_DONE;
                S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_bcd_out <= '0;
        end else if (clr) begin
            r_count   <= '0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_bcd_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_bin   <= w_load;
                        r_bcd   <= '0;
                        r_count <= CNT_W'(BIN_W);
                    end
                end
                S_SHIFT: begin
                    r_bcd   <= w_bcd_shift;
                    r_bin   <= {r_bin[BIN_W-2:0], 1'b0};
                    r_count <= r_count - CNT_W'(1);
                    if (w_last) begin
                        r_bcd_out <= w_bcd_shift;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state == S_SHIFT);
    assign bus.bcd_out   = r_bcd_out;
endmodule
